// File: rtl/lpc_pkg.sv
// Shared LPC definitions: FSM states, cycle-type and sync codes, default I/O window base.
// Pure declarations; no logic, no latency, no flow control.
package lpc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CYCTYPE,
        ADDR,
        WDATA,
        TAR_IN,
        SYNC,
        RDATA,
        TAR_OUT
    } lpcState_t;

    localparam logic [3:0]  IO_RD             = 4'b0000;
    localparam logic [3:0]  IO_WR             = 4'b0010;
    localparam logic [3:0]  START             = 4'b0000;
    localparam logic [3:0]  SYNC_READY        = 4'b0000;
    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0800;

endpackage

// File: rtl/lpc_io_slave_if.sv
// LPC pad signals plus the register-file side (Addr/Wr/DataWr out, RdData in).
// The slave modport is the LPC block; the master modport is the pads/host and register file.
interface lpc_io_slave_if;
    logic       LFrame_n;
    logic [3:0] LadIn;
    logic [3:0] LadOut;
    logic       LadOe;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWr;

    modport slave (
        input  LFrame_n, LadIn, RdData,
        output LadOut, LadOe, Addr, Wr, DataWr
    );

    modport master (
        output LFrame_n, LadIn, RdData,
        input  LadOut, LadOe, Addr, Wr, DataWr
    );
endinterface

// File: rtl/lpc_io_slave.sv
// LPC I/O read/write target for a 32-byte window; SYNC ready at cycle 8 (read) or 10 (write).
// No wait states and no backpressure; the host can abort any frame by pulling LFrame_n low.
module lpc_io_slave
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic          LpcClock,
    input  logic          PciReset,
    lpc_io_slave_if.slave bus
);

    lpcState_t   state;
    logic [1:0]  cnt;
    logic        isWrite;
    logic [11:0] ioAddr;
    logic [7:0]  rdLatch;
    logic [7:0]  wrData;

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            isWrite     <= 1'b0;
            ioAddr      <= 12'h000;
            rdLatch     <= 8'h00;
            wrData      <= 8'h00;
            bus.LadOut  <= 4'hF;
            bus.LadOe   <= 1'b0;
            bus.Wr      <= 1'b0;
            bus.Addr    <= 8'h00;
            bus.DataWr  <= 8'h00;
        end else begin
            bus.Wr <= 1'b0;
            // A low LFrame_n mid-frame wins over everything, including a pending SYNC/Wr.
            if (state != IDLE && !bus.LFrame_n) begin
                bus.LadOe  <= 1'b0;
                bus.LadOut <= 4'hF;
                state      <= (bus.LadIn == START) ? CYCTYPE : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!bus.LFrame_n && bus.LadIn == START)
                            state <= CYCTYPE;
                    end
                    CYCTYPE: begin
                        if (bus.LadIn == IO_RD || bus.LadIn == IO_WR) begin
                            isWrite <= (bus.LadIn == IO_WR);
                            cnt     <= 2'd3;
                            state   <= ADDR;
                        end else begin
                            state   <= IDLE;
                        end
                    end
                    ADDR: begin
                        ioAddr <= {ioAddr[7:0], bus.LadIn};
                        cnt    <= cnt - 2'd1;
                        if (cnt == 2'd0) begin
                            // Last nibble is still on LadIn, so the full address is {ioAddr, LadIn}.
                            if (ioAddr[11:1] == BASE_ADDR[15:5]) begin
                                bus.Addr <= {3'b000, ioAddr[0], bus.LadIn};
                                cnt      <= 2'd1;
                                state    <= isWrite ? WDATA : TAR_IN;
                            end else begin
                                state    <= IDLE;
                            end
                        end
                    end
                    WDATA: begin
                        if (cnt == 2'd1) begin
                            wrData[3:0] <= bus.LadIn;
                            cnt         <= 2'd0;
                        end else begin
                            wrData[7:4] <= bus.LadIn;
                            cnt         <= 2'd1;
                            state       <= TAR_IN;
                        end
                    end
                    TAR_IN: begin
                        if (cnt == 2'd1) begin
                            cnt <= 2'd0;
                        end else begin
                            if (!isWrite)
                                rdLatch <= bus.RdData;
                            state <= SYNC;
                        end
                    end
                    SYNC: begin
                        bus.LadOut <= SYNC_READY;
                        bus.LadOe  <= 1'b1;
                        cnt        <= 2'd1;
                        if (isWrite) begin
                            bus.Wr     <= 1'b1;
                            bus.DataWr <= wrData;
                            state      <= TAR_OUT;
                        end else begin
                            state      <= RDATA;
                        end
                    end
                    RDATA: begin
                        if (cnt == 2'd1) begin
                            bus.LadOut <= rdLatch[3:0];
                            cnt        <= 2'd0;
                        end else begin
                            bus.LadOut <= rdLatch[7:4];
                            cnt        <= 2'd1;
                            state      <= TAR_OUT;
                        end
                    end
                    TAR_OUT: begin
                        bus.LadOut <= 4'hF;
                        if (cnt == 2'd1) begin
                            cnt <= 2'd0;
                        end else begin
                            bus.LadOe <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lpc_io_slave.sv
// Directed LPC frames against lpc_io_slave; cycle k's outputs are sampled 1 ns after edge k.
module tb_lpc_io_slave;
    import lpc_pkg::*;

    logic LpcClock = 1'b0;
    logic PciReset = 1'b0;

    lpc_io_slave_if bus();

    lpc_io_slave #(.BASE_ADDR(16'h0800)) dut (
        .LpcClock (LpcClock),
        .PciReset (PciReset),
        .bus      (bus)
    );

    always #15 LpcClock = ~LpcClock;

    int checks = 0;
    int errors = 0;
    int wrCnt  = 0;

    logic        frSeq  [14];
    logic [3:0]  ladSeq [14];
    logic [3:0]  outLog [14];
    logic [7:0]  addrLog[14];
    logic [13:0] oeMask;
    logic [13:0] wrMask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [3:0] cyc, input logic [15:0] a, input logic [7:0] d);
        for (int k = 0; k < 14; k++) begin
            frSeq[k]  = 1'b1;
            ladSeq[k] = 4'hF;
        end
        frSeq[0]  = 1'b0;
        ladSeq[0] = START;
        ladSeq[1] = cyc;
        ladSeq[2] = a[15:12];
        ladSeq[3] = a[11:8];
        ladSeq[4] = a[7:4];
        ladSeq[5] = a[3:0];
        if (cyc == IO_WR) begin
            ladSeq[6] = d[3:0];
            ladSeq[7] = d[7:4];
        end
        oeMask = '0;
        wrMask = '0;
    endtask

    task automatic idleFill();
        for (int k = 0; k < 14; k++) begin
            frSeq[k]  = 1'b1;
            ladSeq[k] = 4'hF;
        end
        oeMask = '0;
        wrMask = '0;
    endtask

    task automatic run(input int from, input int upto);
        for (int k = from; k < upto; k++) begin
            bus.LFrame_n = frSeq[k];
            bus.LadIn    = ladSeq[k];
            @(posedge LpcClock);
            #1;
            outLog[k]  = bus.LadOut;
            addrLog[k] = bus.Addr;
            oeMask[k]  = bus.LadOe;
            wrMask[k]  = bus.Wr;
            if (bus.Wr) wrCnt++;
        end
    endtask

    initial begin
        int wrBefore;
        bus.LFrame_n = 1'b1;
        bus.LadIn    = 4'hF;
        bus.RdData   = 8'h00;

        // Reset state
        repeat (3) @(posedge LpcClock);
        #1;
        chk("rst_oe",     32'(bus.LadOe),  32'h0);
        chk("rst_out",    32'(bus.LadOut), 32'hF);
        chk("rst_wr",     32'(bus.Wr),     32'h0);
        chk("rst_addr",   32'(bus.Addr),   32'h00);
        chk("rst_datawr", 32'(bus.DataWr), 32'h00);
        @(negedge LpcClock);
        PciReset = 1'b1;

        // Write 0x0808 <- 0x40
        build(IO_WR, 16'h0808, 8'h40);
        run(0, 14);
        chk("wr_wrmask",   32'(wrMask), 32'h0400);
        chk("wr_oemask",   32'(oeMask), 32'h0C00);
        chk("wr_lad",      32'({outLog[11], outLog[10]}), 32'hF0);
        chk("wr_addr_c4",  32'(addrLog[4]), 32'h00);
        chk("wr_addr_c5",  32'(addrLog[5]), 32'h08);
        chk("wr_datawr",   32'(bus.DataWr), 32'h40);

        // Write to 0x0900: outside the window
        build(IO_WR, 16'h0900, 8'h77);
        run(0, 14);
        chk("mis_oemask", 32'(oeMask), 32'h0);
        chk("mis_wrmask", 32'(wrMask), 32'h0);
        chk("mis_addr",   32'(bus.Addr), 32'h08);
        chk("mis_datawr", 32'(bus.DataWr), 32'h40);

        // Read 0x0800, RdData changes after the cycle-7 latch point
        bus.RdData = 8'h3A;
        build(IO_RD, 16'h0800, 8'h00);
        run(0, 8);
        bus.RdData = 8'h55;
        run(8, 14);
        chk("rd_oemask", 32'(oeMask), 32'h0F00);
        chk("rd_lad",    32'({outLog[11], outLog[10], outLog[9], outLog[8]}), 32'hF3A0);
        chk("rd_wrmask", 32'(wrMask), 32'h0);
        chk("rd_addr",   32'(bus.Addr), 32'h00);

        // Write 0x0801 aborted by a new START at cycle 4, then read 0x081F
        wrBefore = wrCnt;
        build(IO_WR, 16'h0801, 8'hAA);
        run(0, 4);
        chk("abt_oe_pre", 32'(oeMask), 32'h0);
        bus.RdData = 8'hC5;
        build(IO_RD, 16'h081F, 8'h00);
        run(0, 14);
        chk("abt_nowr",  wrCnt - wrBefore, 32'h0);
        chk("abt_addr",  32'(bus.Addr), 32'h1F);
        chk("abt_oemask", 32'(oeMask), 32'h0F00);
        chk("abt_lad",   32'({outLog[11], outLog[10], outLog[9], outLog[8]}), 32'hFC50);

        // Read with reset pulsed during cycle 9
        wrBefore = wrCnt;
        bus.RdData = 8'h3A;
        build(IO_RD, 16'h0800, 8'h00);
        run(0, 9);
        chk("rst9_oe_pre", 32'(bus.LadOe), 32'h1);
        PciReset = 1'b0;
        #1;
        chk("rst9_oe",   32'(bus.LadOe), 32'h0);
        chk("rst9_addr", 32'(bus.Addr), 32'h00);
        chk("rst9_out",  32'(bus.LadOut), 32'hF);
        @(negedge LpcClock);
        PciReset = 1'b1;
        idleFill();
        run(0, 5);
        chk("rst9_oe_after", 32'(oeMask), 32'h0);
        chk("rst9_nowr",     wrCnt - wrBefore, 32'h0);
        build(IO_WR, 16'h0810, 8'h9C);
        run(0, 14);
        chk("rst9_wr_wrmask", 32'(wrMask), 32'h0400);
        chk("rst9_wr_oemask", 32'(oeMask), 32'h0C00);
        chk("rst9_wr_data",   32'(bus.DataWr), 32'h9C);
        chk("rst9_wr_addr",   32'(bus.Addr), 32'h10);

        // Memory-read cycle type is ignored, then an I/O read responds
        build(4'b0100, 16'h0800, 8'h00);
        run(0, 14);
        chk("mem_oemask", 32'(oeMask), 32'h0);
        chk("mem_wrmask", 32'(wrMask), 32'h0);
        chk("mem_addr",   32'(bus.Addr), 32'h10);
        bus.RdData = 8'h3A;
        build(IO_RD, 16'h0800, 8'h00);
        run(0, 14);
        chk("mem_rd_oemask", 32'(oeMask), 32'h0F00);
        chk("mem_rd_lad",    32'({outLog[11], outLog[10], outLog[9], outLog[8]}), 32'hF3A0);
        chk("mem_rd_addr",   32'(bus.Addr), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_io_slave.md
LPC_IO_SLAVE -- requirements
Module: lpc_io_slave

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0800, I/O base of the 32-byte register window; bits [4:0] SHALL be ignored.
REQ-002 Reset PciReset, asynchronous, active-low; clock LpcClock.
REQ-003 LpcClock  in  1  33 MHz LPC clock.
REQ-004 PciReset  in  1  asynchronous active-low reset.
REQ-005 LFrame_n  in  1  LPC frame, active-low.
REQ-006 LadIn  in  4  LAD[3:0] as sampled from the pads.
REQ-007 LadOut  out  4  LAD value driven by this block.
REQ-008 LadOe  out  1  LAD pad output enable, active-high.
REQ-009 RdData  in  8  register-file byte selected by Addr.
REQ-010 Addr  out  8  register offset: {3'b000, IOaddr[4:0]}.
REQ-011 Wr  out  1  single-cycle register write strobe.
REQ-012 DataWr  out  8  register write data.

Function
REQ-013 A START SHALL be recognised at an edge where LFrame_n=0 and LadIn=4'b0000. Across consecutive low-LFrame_n cycles, the last such cycle's LadIn decides. That edge is cycle 0.
REQ-014 Cycle 1 LadIn is CYCTYPE: 4'b0000 is an I/O read; 4'b0010 is an I/O write; any other value returns to IDLE and is ignored until the next START.
REQ-015 Cycles 2-5 SHALL shift in address nibbles MSB first.
REQ-016 If IOaddr[15:5] != BASE_ADDR[15:5], the block SHALL return to IDLE and never assert LadOe or Wr for that frame.
REQ-017 On an address match, Addr SHALL update at the cycle-5 edge; it holds its value until the next matched frame.
REQ-018 Read sequence:
- cycles 6-7: host TAR, ignored;
- cycle 8: LadOut=0000, LadOe=1 (SYNC ready);
- RdData SHALL be latched at the cycle-7 edge;
- cycle 9: LadOut=RdData[3:0];
- cycle 10: LadOut=RdData[7:4];
- cycle 11: LadOut=1111, LadOe=1;
- cycle 12: LadOe=0, then IDLE.
REQ-019 Write sequence:
- cycles 6-7: data nibbles, low nibble first;
- cycles 8-9: host TAR;
- cycle 10: SYNC, LadOut=0000, LadOe=1; Wr=1 for exactly this cycle, with DataWr valid;
- cycle 11: LadOut=1111, LadOe=1;
- cycle 12: LadOe=0, then IDLE.
REQ-020 LadOut, LadOe, Wr, Addr and DataWr SHALL all be registered, with no combinational path from LadIn.
REQ-021 Abort: if LFrame_n=0 in any non-IDLE state, the next edge SHALL:
- force LadOe=0;
- suppress any pending Wr;
- restart at cycle 0 if LadIn=0000, otherwise enter IDLE.
REQ-022 LadOe SHALL never be high outside cycles 8-11 (read) or 10-11 (write).
REQ-023 Wr SHALL be asserted at most once per frame.
REQ-024 FSM states: IDLE, CYCTYPE, ADDR (2-bit nibble counter 3..0), WDATA (2), TAR_IN (2), SYNC, RDATA (2), TAR_OUT (2).

Reset
REQ-025 While PciReset=0, outputs SHALL be forced as follows: LadOe=0, LadOut=4'hF, Wr=0, Addr=8'h00, DataWr=8'h00, and FSM=IDLE.
REQ-026 A reset asserted mid-frame SHALL drop LadOe asynchronously, and the frame SHALL be discarded with no Wr.

Structure
REQ-027 The shared package lpc_pkg SHALL hold:
- the FSM state enum;
- the CYCTYPE constants (IO_RD=4'b0000, IO_WR=4'b0010);
- START=4'b0000 and SYNC_READY=4'b0000;
- the default BASE_ADDR.
REQ-028 The block SHALL be a single FSM with no sub-module; it is instantiated in Lpc, driving the register file's Addr/Wr/DataWr ports and reading its selected byte.

Verification
REQ-029 Write to 16'h0808 with data 8'h40: Wr=1 only in cycle 10; Addr=8'h08 and DataWr=8'h40; LAD reads 0000 in cycle 10 and 1111 in cycle 11, then LadOe=0.
REQ-030 Read from 16'h0800 with RdData=8'h3A: LadOut is 0,A,3,F in cycles 8-11 with LadOe=1, then LadOe=0 in cycle 12; Wr stays 0.
REQ-031 Write to 16'h0900 (address mismatch): LadOe and Wr stay 0 for the whole frame; Addr keeps its previous value.
REQ-032 Write to 16'h0801, aborted by LFrame_n=0 with LadIn=0000 at cycle 4, followed by a read of 16'h081F: no Wr occurs; Addr=8'h1F; the read completes per REQ-018.
REQ-033 Read with PciReset pulsed low at cycle 9: LadOe goes 0 immediately and Addr=8'h00; the next write completes normally.
REQ-034 CYCTYPE=4'b0100 (memory read) at 16'h0800: no LadOe and no Wr; a following I/O read responds correctly.
